// File: rtl/ras_recover_ctrl.sv
// Return-address-stack recovery sequencer: forwards fetch push/pop to the speculative stack, rebuilds it from the committed stack on Redirect.
// Latency: fetch forwarding is same-cycle; a recovery of N entries occupies N+2 cycles after Redirect (1 cycle when N=0).
// Backpressure: FetchReady drops on Redirect and while recovering; CmtHold freezes retire-side stack updates while busy.
module ras_recover_ctrl #(
  parameter int RASDEEP = 16,
  parameter int RASPTRW = 4,
  parameter int ADDRW   = 32
) (
  input  logic               Clk,
  input  logic               Rest,
  input  logic               Redirect,
  input  logic [RASPTRW-1:0] CmtPtr,
  input  logic [RASPTRW:0]   CmtCount,
  output logic               CmtRdAble,
  output logic [RASPTRW-1:0] CmtRdAddr,
  input  logic [ADDRW-1:0]   CmtRdDate,
  output logic               CmtHold,
  input  logic               FetchPushReq,
  input  logic [ADDRW-1:0]   FetchPushDate,
  input  logic               FetchPopReq,
  output logic               FetchReady,
  output logic               SpecPushAble,
  output logic [ADDRW-1:0]   SpecPushDate,
  output logic               SpecPopAble,
  output logic               SpecWrAble,
  output logic [RASPTRW-1:0] SpecWrAddr,
  output logic [ADDRW-1:0]   SpecWrDate,
  output logic               SpecPtrLoad,
  output logic [RASPTRW-1:0] SpecPtrVal,
  output logic [RASPTRW:0]   SpecCountVal,
  output logic               RecoverBusy,
  output logic               RecoverDone
);

  // Sequencer states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COPY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] LOAD  = 2'd3;

  // A full stack holds RASDEEP entries, so counts need one more bit than pointers
  localparam logic [RASPTRW:0] DEPTH   = (RASPTRW+1)'(RASDEEP);
  localparam logic [RASPTRW:0] CNT_ONE = (RASPTRW+1)'(1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [RASPTRW-1:0] ptr_q;      // committed pointer captured at Redirect
  logic [RASPTRW:0]   cnt_q;      // clamped committed count captured at Redirect
  logic [RASPTRW:0]   k_q;        // index of the next entry to read
  logic               rd_pend;    // a committed read was issued last cycle
  logic [RASPTRW-1:0] wa_q;       // speculative slot the pending read lands in
  logic               hold_q;

  logic [RASPTRW:0]   cnt_clamp;
  logic [RASPTRW-1:0] base;
  logic [RASPTRW-1:0] rd_addr;
  logic               last_rd;
  logic               copy_go;
  logic               wr_go;
  logic               load_go;

  // A committed count beyond the stack depth still means "stack is full"
  assign cnt_clamp = (CmtCount > DEPTH) ? DEPTH : CmtCount;

  // Oldest valid committed entry; a full stack (count bits wrap to 0) starts at the pointer itself
  assign base    = ptr_q - cnt_q[RASPTRW-1:0];
  assign rd_addr = base + k_q[RASPTRW-1:0];
  assign last_rd = (k_q == (cnt_q - CNT_ONE));

  // Next-state: Redirect restarts recovery from any state and wins over normal progress
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      COPY:    state_nxt = last_rd ? DRAIN : COPY;
      DRAIN:   state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (Redirect) begin
      state_nxt = (cnt_clamp != '0) ? COPY : LOAD;
    end
  end

  // State, captured committed snapshot and copy bookkeeping
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      state   <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      rd_pend <= 1'b0;
      wa_q    <= '0;
    end else begin
      state <= state_nxt;
      if (Redirect) begin
        // Fresh snapshot; anything still in flight from an earlier copy is dropped
        ptr_q   <= CmtPtr;
        cnt_q   <= cnt_clamp;
        k_q     <= '0;
        rd_pend <= 1'b0;
      end else if (state == COPY) begin
        k_q     <= k_q + CNT_ONE;
        rd_pend <= 1'b1;
        wa_q    <= rd_addr;
      end else begin
        rd_pend <= 1'b0;
      end
    end
  end

  // Retire hold flop tracks the state register so it is glitch-free toward retire
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= (state_nxt != IDLE);
    end
  end

  // A Redirect cycle suppresses every recovery side effect of the state being abandoned
  assign copy_go = (state == COPY) && !Redirect;
  assign wr_go   = rd_pend && ((state == COPY) || (state == DRAIN)) && !Redirect;
  assign load_go = (state == LOAD) && !Redirect;

  // Fetch passthrough only when idle, not flushing and not in reset
  assign FetchReady   = (state == IDLE) && !Redirect && !Rest;
  assign SpecPushAble = FetchPushReq && FetchReady;
  assign SpecPushDate = SpecPushAble ? FetchPushDate : '0;
  assign SpecPopAble  = FetchPopReq && FetchReady;

  // Committed read port: one entry per COPY cycle, data returns the following cycle
  assign CmtRdAble = copy_go;
  assign CmtRdAddr = copy_go ? rd_addr : '0;

  // Speculative line write with the data returned from last cycle's read
  assign SpecWrAble = wr_go;
  assign SpecWrAddr = wr_go ? wa_q : '0;
  assign SpecWrDate = wr_go ? CmtRdDate : '0;

  // Final pointer/count load closes the recovery
  assign SpecPtrLoad  = load_go;
  assign SpecPtrVal   = load_go ? ptr_q : '0;
  assign SpecCountVal = load_go ? cnt_q : '0;
  assign RecoverDone  = load_go;

  assign CmtHold     = hold_q;
  assign RecoverBusy = (state != IDLE);

endmodule
